// File: rtl/msrv32_rf_wb_arbiter.sv
// msrv32_rf_wb_arbiter
// Shares the single write port of msrv32_integer_file among NUM_SRC
// writeback requesters (0 = ALU, 1 = LSU, 2 = CSR).
// Grants are combinational. The write presented to the integer file is registered.
// Writes to x0 complete the handshake but never reach the file.
// A saturating counter tracks committed (non-x0) writes.
// Build option: define MSRV32_WB_RR_ARB_EN for round-robin arbitration.
// When it is undefined, fixed priority applies and the lowest index wins.
module msrv32_rf_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                      ms_riscv32_mp_clk_in,
  input  logic                      ms_riscv32_mp_rst_in,
  input  logic                      stall_in,
  input  logic [NUM_SRC-1:0]        src_valid_in,
  input  logic [NUM_SRC*ADDR_W-1:0] src_rd_addr_in,
  input  logic [NUM_SRC*DATA_W-1:0] src_rd_data_in,
  output logic [NUM_SRC-1:0]        src_ready_out,
  output logic                      wr_en_out,
  output logic [ADDR_W-1:0]         rd_addr_out,
  output logic [DATA_W-1:0]         rd_out,
  output logic [1:0]                grant_id_out,
  output logic [CNT_W-1:0]          wb_count_out
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  logic              found_d;
  logic [1:0]        idx_d;
  logic              xfer_d;
  logic [ADDR_W-1:0] gaddr_d;
  logic [DATA_W-1:0] gdata_d;

  logic              wr_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [1:0]        gid_q;
  logic [CNT_W-1:0]  cnt_q;

`ifdef MSRV32_WB_RR_ARB_EN
  logic [1:0] ptr_q;

  // Round-robin search: first sources above the last winner, then wrap to index 0.
  always_comb begin
    found_d = 1'b0;
    idx_d   = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found_d && src_valid_in[i] && (i > int'(ptr_q))) begin
        found_d = 1'b1;
        idx_d   = 2'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found_d && src_valid_in[i]) begin
        found_d = 1'b1;
        idx_d   = 2'(i);
      end
    end
  end

  // The pointer only moves on a real transfer, so a stalled winner keeps its turn.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) ptr_q <= 2'(NUM_SRC - 1);
    else if (xfer_d)          ptr_q <= idx_d;
  end
`else
  // Fixed priority: the lowest-indexed valid source wins.
  always_comb begin
    found_d = 1'b0;
    idx_d   = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found_d && src_valid_in[i]) begin
        found_d = 1'b1;
        idx_d   = 2'(i);
      end
    end
  end
`endif

  // Grant and the winner's payload. Ready stays low under stall and reset.
  always_comb begin
    xfer_d        = found_d & ~stall_in & ~ms_riscv32_mp_rst_in;
    src_ready_out = xfer_d ? (NUM_SRC'(1) << idx_d) : '0;
    gaddr_d       = '0;
    gdata_d       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (idx_d == 2'(i)) begin
        gaddr_d = src_rd_addr_in[i*ADDR_W +: ADDR_W];
        gdata_d = src_rd_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output stage: the enable is reloaded every cycle; the payload holds between transfers.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= 2'd0;
    end else begin
      wr_en_q <= xfer_d & (gaddr_d != '0);
      if (xfer_d) begin
        addr_q <= gaddr_d;
        data_q <= gdata_d;
        gid_q  <= idx_d;
      end
    end
  end

  // Count each cycle in which a write actually reaches the integer file.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) cnt_q <= '0;
    else if (wr_en_q)         cnt_q <= sat_inc(cnt_q);
  end

  // Reset drops any write already sitting in the stage, so it never reaches the file.
  assign wr_en_out    = wr_en_q & ~ms_riscv32_mp_rst_in;
  assign rd_addr_out  = addr_q;
  assign rd_out       = data_q;
  assign grant_id_out = gid_q;
  assign wb_count_out = cnt_q;

endmodule

// File: tb/tb_msrv32_rf_wb_arbiter.sv
// Scoreboard bench for msrv32_rf_wb_arbiter (small counter to reach saturation).
module tb_msrv32_rf_wb_arbiter;
  localparam int NS = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic [NS-1:0]    valid  = '0;
  logic [NS*AW-1:0] addr_v = '0;
  logic [NS*DW-1:0] data_v = '0;
  logic [NS-1:0] ready;
  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [1:0]    gid;
  logic [CW-1:0] cnt;

  msrv32_rf_wb_arbiter #(.NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .stall_in(stall),
    .src_valid_in(valid),
    .src_rd_addr_in(addr_v),
    .src_rd_data_in(data_v),
    .src_ready_out(ready),
    .wr_en_out(wr_en),
    .rd_addr_out(rd_addr),
    .rd_out(rd_data),
    .grant_id_out(gid),
    .wb_count_out(cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    id;
  } xfer_t;
  xfer_t exp_q[$];

  // Reference model: pending requests per source and the last winner.
  bit            pv[NS];
  logic [AW-1:0] pa[NS];
  logic [DW-1:0] pd[NS];
  int            last = NS - 1;
  bit            started = 1'b0;

  int passed = 0;
  int total  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Expected winner among pending requests, or -1 if there is none.
  function automatic int pick();
`ifdef MSRV32_WB_RR_ARB_EN
    for (int k = 1; k <= NS; k++) begin
      int s = (last + k) % NS;
      if (pv[s]) return s;
    end
`else
    for (int s = 0; s < NS; s++) if (pv[s]) return s;
`endif
    return -1;
  endfunction

  task automatic tick(input bit r, input bit st);
    int g;
    logic [NS-1:0] er;
    @(posedge clk);
    #1;
    rst   = r;
    stall = st;
    if (r) begin
      exp_q.delete();
      for (int s = 0; s < NS; s++) pv[s] = 1'b0;
      last = NS - 1;
    end
    for (int s = 0; s < NS; s++) begin
      valid[s]            = pv[s];
      addr_v[s*AW +: AW]  = pa[s];
      data_v[s*DW +: DW]  = pd[s];
    end
    #2;
    g  = (r || st) ? -1 : pick();
    er = (g < 0) ? '0 : NS'(1 << g);
    check("ready", 64'(ready), 64'(er));
    if (g >= 0) begin
      exp_q.push_back('{due: cyc + 1, a: pa[g], d: pd[g], id: 2'(g)});
      pv[g] = 1'b0;
      last  = g;
    end
    started = 1'b1;
  endtask

  task automatic gen();
    for (int s = 0; s < NS; s++) begin
      if (!pv[s] && ($urandom_range(0, 1) == 1)) begin
        pv[s] = 1'b1;
        pa[s] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        pd[s] = $urandom;
      end
    end
  endtask

  task automatic req(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pv[s] = 1'b1;
    pa[s] = a;
    pd[s] = d;
  endtask

  // Monitor: pops the transfer due this cycle and checks what reaches the integer file.
  int            exp_cnt  = 0;
  bit            post_rst = 1'b0;
  logic [AW-1:0] hold_a   = '0;
  logic [DW-1:0] hold_d   = '0;
  logic [1:0]    hold_id  = '0;
  always @(negedge clk) begin
    if (started) begin
      if (rst) begin
        check("wr_en_in_reset", 64'(wr_en), 64'(0));
        exp_cnt  = 0;
        post_rst = 1'b1;
        hold_a   = '0;
        hold_d   = '0;
        hold_id  = '0;
      end else begin
        bit    due;
        bit    exp_wr;
        xfer_t e;
        due    = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_wr = 1'b0;
        if (due) begin
          e       = exp_q.pop_front();
          exp_wr  = (e.a != '0);
          hold_a  = e.a;
          hold_d  = e.d;
          hold_id = e.id;
        end
        if (post_rst) check("cnt_after_reset", 64'(cnt), 64'(0));
        post_rst = 1'b0;
        check("wb_count", 64'(cnt), 64'(exp_cnt));
        check("wr_en", 64'(wr_en), 64'(exp_wr));
        check("rd_addr", 64'(rd_addr), 64'(hold_a));
        check("rd_data", 64'(rd_data), 64'(hold_d));
        check("grant_id", 64'(gid), 64'(hold_id));
        if (exp_wr && exp_cnt < (1 << CW) - 1) exp_cnt++;
      end
    end
  end

  initial begin
    for (int s = 0; s < NS; s++) begin
      pv[s] = 1'b0;
      pa[s] = '0;
      pd[s] = '0;
    end
    tick(1, 0);
    tick(1, 0);
    // Single ALU write.
    req(0, 5'd1, 32'hA5A5_A5A5);
    tick(0, 0); tick(0, 0); tick(0, 0);
    // Three simultaneous requesters.
    req(0, 5'd2, 32'h5A5A_5A5A);
    req(1, 5'd3, 32'h1234_5678);
    req(2, 5'd6, 32'hF0F0_F0F0);
    repeat (4) tick(0, 0);
    // Write to x0 from the LSU.
    req(1, 5'd0, 32'hFFFF_FFFF);
    tick(0, 0); tick(0, 0);
    // Stall with the CSR waiting, then release.
    req(2, 5'd7, 32'hAAAA_AAAA);
    repeat (3) tick(0, 1);
    tick(0, 0); tick(0, 0);
    // Transfer immediately followed by reset.
    req(0, 5'd8, 32'h5555_5555);
    tick(0, 0);
    tick(1, 0);
    tick(0, 0); tick(0, 0);
    // Contention ahead of a stall.
    req(0, 5'd9, 32'h0000_0009);
    req(1, 5'd10, 32'h0000_000A);
    tick(0, 0); tick(0, 1); tick(0, 0); tick(0, 0);
    // Random traffic; long reset-free stretches drive the counter to saturation.
    repeat (400) begin
      gen();
      tick(($urandom_range(0, 149) == 0), ($urandom_range(0, 4) == 0));
    end
    for (int s = 0; s < NS; s++) pv[s] = 1'b0;
    repeat (4) tick(0, 0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
